// File: rtl/conv1_fmap_reader_pkg.sv
// Shared parameters and types for conv1 layer and its reader.
// Used by the conv layer, the fmap reader and the pool stage.
package conv1_fmap_reader_pkg;

  localparam int N_CH  = 18;
  localparam int FMAP  = 24;
  localparam int CH_W  = $clog2(N_CH);
  localparam int ROW_W = $clog2(FMAP);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FIN
  } rd_state_t;

endpackage

// File: rtl/conv1_fmap_reader_if.sv
// Row-beat valid/ready stream from the conv1 feature-map reader.
// Master drives beats; slave returns ready.
interface conv1_fmap_reader_if;
  import conv1_fmap_reader_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [FMAP-1:0]  out_data;
  logic [CH_W-1:0]  out_ch;
  logic [ROW_W-1:0] out_row;
  logic             out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_ch,
    output out_row,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_ch,
    input  out_row,
    input  out_last
  );

endinterface

// File: rtl/conv1_fmap_reader.sv
// Snapshots the conv1 binary feature map on start and streams it
// out one row per beat so the conv stage can be re-driven meanwhile.
module conv1_fmap_reader
  import conv1_fmap_reader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fmap_in [N_CH][FMAP][FMAP],
  input  logic start,
  output logic busy,
  output logic done,
  conv1_fmap_reader_if.master rd
);

  rd_state_t        state_q;
  rd_state_t        state_d;
  logic [CH_W-1:0]  ch_q;
  logic [ROW_W-1:0] row_q;
  logic [FMAP-1:0]  snap [N_CH][FMAP];

  logic capture;
  logic hs;
  logic row_end;
  logic ch_end;

  assign capture = (state_q == IDLE) && start;
  assign hs      = (state_q == STREAM) && rd.out_ready;
  assign row_end = (row_q == ROW_W'(FMAP - 1));
  assign ch_end  = (ch_q == CH_W'(N_CH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (hs && row_end && ch_end) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Two-level index: row is the inner counter, ch the outer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      row_q <= '0;
    end else if (capture) begin
      ch_q  <= '0;
      row_q <= '0;
    end else if (hs) begin
      if (row_end) begin
        row_q <= '0;
        ch_q  <= ch_end ? '0 : ch_q + 1'b1;
      end else begin
        row_q <= row_q + 1'b1;
      end
    end
  end

  // Column 0 lands in the MSB of each stored row word.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int c = 0; c < N_CH; c++)
        for (int r = 0; r < FMAP; r++)
          for (int k = 0; k < FMAP; k++)
            snap[c][r][FMAP-1-k] <= fmap_in[c][r][k];
    end
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    rd.out_valid = 1'b0;
    rd.out_last  = 1'b0;
    rd.out_data  = '0;
    rd.out_ch    = ch_q;
    rd.out_row   = row_q;
    unique case (state_q)
      STREAM: begin
        busy         = 1'b1;
        rd.out_valid = 1'b1;
        rd.out_data  = snap[ch_q][row_q];
        rd.out_last  = row_end && ch_end;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv1_fmap_reader.sv
// Directed bench for conv1_fmap_reader: ordering, backpressure,
// snapshot isolation, mid-stream reset and data boundaries.
module tb_conv1_fmap_reader;
  import conv1_fmap_reader_pkg::*;

  logic clk = 0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic fmap [N_CH][FMAP][FMAP];
  logic ref_map [N_CH][FMAP][FMAP];

  int total = 0;
  int bad   = 0;

  conv1_fmap_reader_if rd_if ();

  conv1_fmap_reader dut (
    .clk     (clk),
    .rst     (rst),
    .fmap_in (fmap),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd      (rd_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [FMAP-1:0] exp_row(input int c, input int r);
    logic [FMAP-1:0] v;
    for (int k = 0; k < FMAP; k++) v[FMAP-1-k] = ref_map[c][r][k];
    return v;
  endfunction

  task automatic fill(input int kind);
    for (int c = 0; c < N_CH; c++)
      for (int r = 0; r < FMAP; r++)
        for (int k = 0; k < FMAP; k++)
          case (kind)
            0: fmap[c][r][k] = ((c + r + k) % 3 == 0);
            1: fmap[c][r][k] = 1'b0;
            2: fmap[c][r][k] = 1'b1;
            default:
              fmap[c][r][k] = (c == N_CH-1 && r == FMAP-1 && k == 0);
          endcase
  endtask

  // mode 0: ready always 1, mode 1: ready ~30% duty
  task automatic run_frame(input int mode, input int poke,
                           input int abort_at, input string tag);
    int beat = 0;
    int cyc;
    bit seen_done = 0;
    bit stalled = 0;
    logic [FMAP-1:0] pd;
    logic [CH_W-1:0] pch;
    logic [ROW_W-1:0] prow;
    ref_map = fmap;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 4000) begin
      rd_if.out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      start = (poke != 0 && cyc == 6);
      if (poke != 0 && cyc == 6) fill(2);
      if (done) begin
        seen_done = 1;
        if (mode == 0) chk({tag, "_done_cyc"}, cyc, 433);
        chk({tag, "_busy_fin"}, busy, 0);
        break;
      end
      if (beat == abort_at) begin
        rst = 1'b1;
        #1;
        chk({tag, "_abort_valid"}, rd_if.out_valid, 0);
        chk({tag, "_abort_busy"}, busy, 0);
        chk({tag, "_abort_row"}, rd_if.out_row, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk({tag, "_abort_nodone"}, done, 0);
        end
        return;
      end
      chk({tag, "_valid"}, rd_if.out_valid, 1);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_ch"}, rd_if.out_ch, beat / FMAP);
      chk({tag, "_row"}, rd_if.out_row, beat % FMAP);
      chk({tag, "_data"}, rd_if.out_data,
          exp_row(beat / FMAP, beat % FMAP));
      chk({tag, "_last"}, rd_if.out_last, beat == N_CH*FMAP-1);
      if (stalled) begin
        chk({tag, "_hold_data"}, rd_if.out_data, pd);
        chk({tag, "_hold_idx"}, {rd_if.out_ch, rd_if.out_row},
            {pch, prow});
      end
      pd = rd_if.out_data;
      pch = rd_if.out_ch;
      prow = rd_if.out_row;
      stalled = !rd_if.out_ready;
      if (rd_if.out_ready) beat++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, seen_done, 1);
    chk({tag, "_beats"}, beat, N_CH*FMAP);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_valid"}, rd_if.out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rd_if.out_ready = 1'b0;
    fill(1);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", rd_if.out_valid, 0);
    chk("rst_last", rd_if.out_last, 0);
    chk("rst_ch", rd_if.out_ch, 0);
    chk("rst_row", rd_if.out_row, 0);
    chk("rst_data", rd_if.out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    fill(0);
    run_frame(0, 0, -1, "t2");
    run_frame(1, 0, -1, "t3");
    run_frame(0, 1, -1, "t4");
    fill(0);
    run_frame(0, 0, 100, "t5");
    run_frame(0, 0, -1, "t5b");
    fill(1);
    run_frame(0, 0, -1, "zero");
    fill(2);
    run_frame(0, 0, -1, "ones");
    fill(3);
    run_frame(0, 0, -1, "single");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
